// File: rtl/apb_protocol_checker_if.sv
// APB bus bundle shared by master, slave and the passive protocol checker.
interface apb_protocol_checker_if #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 16,
   parameter int NUM_SLV = 4
);
   logic [ADDR_W-1:0]  paddr;
   logic               pwrite;
   logic [NUM_SLV-1:0] psel;
   logic               penable;
   logic [DATA_W-1:0]  pwdata;
   logic               pready;
   logic [DATA_W-1:0]  prdata;
   logic               pslverr;

   modport master  (output paddr, pwrite, psel, penable, pwdata,
                    input  pready, prdata, pslverr);
   modport slave   (input  paddr, pwrite, psel, penable, pwdata,
                    output pready, prdata, pslverr);
   modport monitor (input  paddr, pwrite, psel, penable, pwdata,
                           pready, prdata, pslverr);
endinterface

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker: tracks the bus phase, reports the highest-priority violation
// one cycle after the offending edge, and keeps saturating statistics. X/Z checks (code 7) are
// compiled in only when APB_CHK_XPROP_EN is defined.
//
// state  | meaning
// IDLE   | no transfer open, waiting for a single PSEL
// SETUP  | setup phase observed, PENABLE expected next
// ACCESS | access phase stalled by PREADY low (wait states)
module apb_protocol_checker #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 16,
   parameter int NUM_SLV  = 4,
   parameter int TIMEOUT  = 16,
   parameter int CNT_W    = 16,
   localparam int SW      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic                    chk_en,
   input  logic                    clr,
   apb_protocol_checker_if.monitor bus,
   output logic                    viol_valid,
   output logic [3:0]              viol_code,
   output logic [SW-1:0]           viol_slv,
   output logic [ADDR_W-1:0]       viol_addr,
   output logic [CNT_W-1:0]        viol_cnt,
   output logic [CNT_W-1:0]        xfer_cnt,
   output logic [CNT_W-1:0]        slverr_cnt,
   output logic [3:0]              first_code,
   output logic                    irq
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   state_e              state_q, state_d;
   logic                mask_q;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]       slv_q, slv_d;
   logic [CNT_W-1:0]    wait_q, wait_d;
   logic                viol_valid_q, viol_valid_d;
   logic [3:0]          viol_code_q, viol_code_d;
   logic [SW-1:0]       viol_slv_q, viol_slv_d;
   logic [ADDR_W-1:0]   viol_addr_q, viol_addr_d;
   logic [CNT_W-1:0]    viol_cnt_q, viol_cnt_d;
   logic [CNT_W-1:0]    xfer_cnt_q, xfer_cnt_d;
   logic [CNT_W-1:0]    slverr_cnt_q, slverr_cnt_d;
   logic [3:0]          first_code_q, first_code_d;

   logic [SW-1:0]       psel_idx;
   logic                psel_any, psel_multi, mismatch;
   logic                capture, access_cycle, done, report, xprop_viol;
   logic [8:1]          fsm_v, all_v;
   logic [3:0]          code_sel;

   assign psel_any   = |bus.psel;
   assign psel_multi = |(bus.psel & (bus.psel - NUM_SLV'(1)));

   always_comb begin
      psel_idx = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (bus.psel[i]) psel_idx = SW'(i);
      end
   end

   assign mismatch = (bus.paddr != addr_q) || (bus.pwrite != write_q) || (psel_idx != slv_q)
                     || (bus.pwrite && (bus.pwdata != wdata_q));

   always_comb begin
      state_d      = state_q;
      fsm_v        = '0;
      capture      = 1'b0;
      access_cycle = 1'b0;
      done         = 1'b0;
      wait_d       = wait_q;
      if (mask_q) begin
         // first cycle out of reset: adopt whatever phase the bus is in, report nothing
         if (psel_any) begin
            capture = 1'b1;
            state_d = bus.penable ? ACCESS : SETUP;
         end else begin
            state_d = IDLE;
         end
      end else if (psel_multi) begin
         fsm_v[1] = 1'b1;
         state_d  = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (psel_any) begin
                  capture = 1'b1;
                  if (bus.penable) begin
                     fsm_v[2] = 1'b1;
                     state_d  = ACCESS;
                  end else begin
                     state_d  = SETUP;
                  end
               end
            end
            SETUP: begin
               if (!psel_any) begin
                  fsm_v[3] = 1'b1;
                  state_d  = IDLE;
               end else begin
                  fsm_v[4] = mismatch;
                  if (!bus.penable) begin
                     fsm_v[3] = 1'b1;
                     capture  = 1'b1;
                  end else begin
                     access_cycle = 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (!psel_any || !bus.penable) begin
                  fsm_v[5] = !bus.pready;
                  if (psel_any) begin
                     capture = 1'b1;
                     state_d = SETUP;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  fsm_v[4]     = mismatch;
                  access_cycle = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (access_cycle) begin
         if (bus.pready) begin
            done    = 1'b1;
            state_d = IDLE;
         end else begin
            state_d  = ACCESS;
            fsm_v[8] = bus.pslverr;
            // wait timer counts down from TIMEOUT; terminal count fires once and then sticks at 0
            fsm_v[6] = (wait_q == CNT_W'(1));
            if (wait_q != '0) wait_d = wait_q - CNT_W'(1);
         end
      end
      if (capture) wait_d = CNT_W'(TIMEOUT);
   end

   assign addr_d  = capture ? bus.paddr  : addr_q;
   assign write_d = capture ? bus.pwrite : write_q;
   assign wdata_d = capture ? bus.pwdata : wdata_q;
   assign slv_d   = capture ? psel_idx   : slv_q;

`ifdef APB_CHK_XPROP_EN
   always_comb begin
      xprop_viol = $isunknown(bus.psel)
         || ((bus.psel != '0) && ($isunknown(bus.penable) || $isunknown(bus.pwrite)
                                  || $isunknown(bus.paddr)))
         || ((bus.pwrite === 1'b1) && $isunknown(bus.pwdata))
         || (access_cycle && (bus.pready === 1'b1) && (bus.pwrite === 1'b0)
             && (bus.pslverr === 1'b0) && $isunknown(bus.prdata));
   end
`else
   logic prdata_unused;
   assign prdata_unused = ^bus.prdata;
   assign xprop_viol    = 1'b0;
`endif

   always_comb begin
      all_v    = fsm_v;
      all_v[7] = xprop_viol && !mask_q;
      code_sel = 4'd0;
      if      (all_v[1]) code_sel = 4'd1;
      else if (all_v[7]) code_sel = 4'd7;
      else if (all_v[2]) code_sel = 4'd2;
      else if (all_v[3]) code_sel = 4'd3;
      else if (all_v[4]) code_sel = 4'd4;
      else if (all_v[5]) code_sel = 4'd5;
      else if (all_v[6]) code_sel = 4'd6;
      else if (all_v[8]) code_sel = 4'd8;
   end

   always_comb begin
      report       = (all_v != '0) && chk_en && !mask_q;
      viol_valid_d = report;
      viol_code_d  = report ? code_sel : viol_code_q;
      viol_slv_d   = report ? ((state_q == IDLE) ? psel_idx : slv_q) : viol_slv_q;
      viol_addr_d  = report ? ((state_q == IDLE) ? bus.paddr : addr_q) : viol_addr_q;
      viol_cnt_d   = viol_cnt_q;
      xfer_cnt_d   = xfer_cnt_q;
      slverr_cnt_d = slverr_cnt_q;
      first_code_d = first_code_q;
      if (report && (viol_cnt_q != '1))                  viol_cnt_d   = viol_cnt_q + CNT_W'(1);
      if (done && (xfer_cnt_q != '1))                    xfer_cnt_d   = xfer_cnt_q + CNT_W'(1);
      if (done && bus.pslverr && (slverr_cnt_q != '1))   slverr_cnt_d = slverr_cnt_q + CNT_W'(1);
      if (report && (first_code_q == 4'd0))              first_code_d = code_sel;
      if (clr) begin
         viol_cnt_d   = '0;
         xfer_cnt_d   = '0;
         slverr_cnt_d = '0;
         first_code_d = 4'd0;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q      <= IDLE;
         mask_q       <= 1'b1;
         addr_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         slv_q        <= '0;
         wait_q       <= '0;
         viol_valid_q <= 1'b0;
         viol_code_q  <= 4'd0;
         viol_slv_q   <= '0;
         viol_addr_q  <= '0;
         viol_cnt_q   <= '0;
         xfer_cnt_q   <= '0;
         slverr_cnt_q <= '0;
         first_code_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         mask_q       <= 1'b0;
         addr_q       <= addr_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         slv_q        <= slv_d;
         wait_q       <= wait_d;
         viol_valid_q <= viol_valid_d;
         viol_code_q  <= viol_code_d;
         viol_slv_q   <= viol_slv_d;
         viol_addr_q  <= viol_addr_d;
         viol_cnt_q   <= viol_cnt_d;
         xfer_cnt_q   <= xfer_cnt_d;
         slverr_cnt_q <= slverr_cnt_d;
         first_code_q <= first_code_d;
      end
   end

   assign viol_valid = viol_valid_q;
   assign viol_code  = viol_code_q;
   assign viol_slv   = viol_slv_q;
   assign viol_addr  = viol_addr_q;
   assign viol_cnt   = viol_cnt_q;
   assign xfer_cnt   = xfer_cnt_q;
   assign slverr_cnt = slverr_cnt_q;
   assign first_code = first_code_q;
   assign irq        = (first_code_q != 4'd0);
endmodule
